// File: rtl/ghost_catch_ctrl.sv
// Ghost/Pac-Man catch controller: debounced catch, freeze, life count, respawn and game-over.
// Optional post-respawn invulnerability window is enabled by defining GHOST_CATCH_INVULN_EN.
module ghost_catch_ctrl #(
    parameter int unsigned HIT_DIST     = 12,
    parameter int unsigned FREEZE_TICKS = 60,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned INVULN_TICKS = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] ghost_x,
    input  logic [8:0] ghost_y,
    input  logic [9:0] pac_x,
    input  logic [8:0] pac_y,
    input  logic       restart,
    output logic       freeze,
    output logic       caught,
    output logic       respawn,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned LIVES_W = 2;
    // One counter serves both the freeze and invulnerability periods, sized for the longer one.
    localparam int unsigned CNT_MAX = (FREEZE_TICKS > INVULN_TICKS) ? FREEZE_TICKS : INVULN_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   FREEZE_LAST = CNT_W'(FREEZE_TICKS);
`ifdef GHOST_CATCH_INVULN_EN
    localparam logic [CNT_W-1:0]   INVULN_LAST = CNT_W'(INVULN_TICKS);
`endif
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);

    typedef enum logic [2:0] {
        S_PLAY,
        S_CONFIRM,
        S_CAUGHT,
        S_RESPAWN,
        S_GAMEOVER
`ifdef GHOST_CATCH_INVULN_EN
        , S_INVULN
`endif
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic               freeze_d, caught_d, respawn_d, game_over_d;
    logic [LIVES_W-1:0] lives_d;
    logic [X_W-1:0]     dx;
    logic [Y_W-1:0]     dy;
    logic               overlap_c;

    // Absolute axis distances without wrap, then box test.
    always_comb begin
        dx        = (ghost_x >= pac_x) ? (ghost_x - pac_x) : (pac_x - ghost_x);
        dy        = (ghost_y >= pac_y) ? (ghost_y - pac_y) : (pac_y - ghost_y);
        overlap_c = (dx < X_W'(HIT_DIST)) && (dy < Y_W'(HIT_DIST));
        cnt_inc   = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_PLAY;
            cnt       <= '0;
            freeze    <= 1'b0;
            caught    <= 1'b0;
            respawn   <= 1'b0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            freeze    <= freeze_d;
            caught    <= caught_d;
            respawn   <= respawn_d;
            lives     <= lives_d;
            game_over <= game_over_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        freeze_d    = freeze;
        caught_d    = 1'b0;
        respawn_d   = 1'b0;
        lives_d     = lives;
        game_over_d = game_over;
        case (state)
            S_PLAY: begin
                if (frame_tick && overlap_c) begin
                    state_d = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (frame_tick) begin
                    if (overlap_c) begin
                        state_d  = S_CAUGHT;
                        caught_d = 1'b1;
                        freeze_d = 1'b1;
                        cnt_d    = '0;
                        lives_d  = (lives == '0) ? lives : (lives - LIVES_W'(1));
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_CAUGHT: begin
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FREEZE_LAST) begin
                        if (lives == '0) begin
                            state_d     = S_GAMEOVER;
                            game_over_d = 1'b1;
                        end else begin
                            state_d   = S_RESPAWN;
                            respawn_d = 1'b1;
                        end
                    end
                end
            end
            S_RESPAWN: begin
                freeze_d = 1'b0;
`ifdef GHOST_CATCH_INVULN_EN
                state_d  = S_INVULN;
                cnt_d    = '0;
`else
                state_d  = S_PLAY;
`endif
            end
            S_GAMEOVER: begin
                if (restart) begin
                    state_d     = S_RESPAWN;
                    respawn_d   = 1'b1;
                    lives_d     = LIVES_INIT;
                    game_over_d = 1'b0;
                end
            end
`ifdef GHOST_CATCH_INVULN_EN
            S_INVULN: begin
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == INVULN_LAST) begin
                        state_d = S_PLAY;
                    end
                end
            end
`endif
            default: begin
                state_d = S_PLAY;
            end
        endcase
    end

endmodule
